// File: rtl/redmule_tile_pkg.sv
// redmule_tile_pkg: tile OBI instruction channel types and instruction arbiter constants.
package redmule_tile_pkg;
  localparam int unsigned INSTR_ARB_NUM_REQ = 2;
  localparam int unsigned INSTR_ARB_MAX_OUTSTANDING = 4;
  typedef struct packed {
    logic [31:0] addr;
  } core_obi_instr_a_chan_t;
  typedef struct packed {
    logic                   req;
    core_obi_instr_a_chan_t a;
  } core_obi_instr_req_t;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } core_obi_instr_r_chan_t;
  typedef struct packed {
    logic                   gnt;
    logic                   rvalid;
    core_obi_instr_r_chan_t r;
  } core_obi_instr_rsp_t;
  typedef logic [$clog2(INSTR_ARB_NUM_REQ)-1:0] instr_arb_id_t;
endpackage

// File: rtl/obi_instr_arb_id_fifo.sv
// obi_instr_arb_id_fifo: in-order FIFO of requester IDs for outstanding transactions.
module obi_instr_arb_id_fifo
  import redmule_tile_pkg::*;
#(
  parameter int unsigned Depth = INSTR_ARB_MAX_OUTSTANDING,
  parameter int unsigned W     = $bits(instr_arb_id_t),
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    data,
  output logic [W-1:0]    head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);
  logic [W-1:0]    mem [Depth];
  logic [PtrW-1:0] wr_q, rd_q;
  logic            do_push, do_pop;
  function automatic logic [PtrW-1:0] nxt(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full    = count == CntW'(Depth);
  assign empty   = count == '0;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_q];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop) rd_q <= nxt(rd_q);
      count <= count + CntW'(do_push) - CntW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= data;
  end
endmodule

// File: rtl/obi_instr_arbiter.sv
// obi_instr_arbiter: round-robin OBI instruction arbiter with in-order response routing.
// Optional performance counters enabled by OBI_INSTR_ARB_PERF_EN.
module obi_instr_arbiter
  import redmule_tile_pkg::*;
#(
  parameter int unsigned NumReq         = INSTR_ARB_NUM_REQ,
  parameter int unsigned MaxOutstanding = INSTR_ARB_MAX_OUTSTANDING
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  core_obi_instr_req_t [NumReq-1:0]   slv_req_i,
  output core_obi_instr_rsp_t [NumReq-1:0]   slv_rsp_o,
  output core_obi_instr_req_t                mst_req_o,
  input  core_obi_instr_rsp_t                mst_rsp_i,
  output logic                               busy_o,
`ifdef OBI_INSTR_ARB_PERF_EN
  output logic [NumReq-1:0][31:0]            perf_grant_cnt_o,
  output logic [31:0]                        perf_stall_cnt_o,
  input  logic                               perf_clr_i,
`endif
  output logic                               rsp_err_o
);
  localparam int unsigned IdW  = $clog2(NumReq);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  logic [IdW-1:0]  rr_q, lock_id_q, win, head;
  logic            lock_q, win_vld, hs, pop, full, empty;
  logic [CntW-1:0] count;
  always_comb begin
    win     = rr_q;
    win_vld = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (slv_req_i[(int'(rr_q) + i) % NumReq].req) begin
        win     = IdW'((int'(rr_q) + i) % NumReq);
        win_vld = 1'b1;
      end
    end
    if (lock_q) begin
      win     = lock_id_q;
      win_vld = slv_req_i[lock_id_q].req;
    end
  end
  assign mst_req_o.req = win_vld & ~full;
  assign mst_req_o.a   = slv_req_i[win].a;
  assign hs            = mst_req_o.req & mst_rsp_i.gnt;
  assign pop           = mst_rsp_i.rvalid & ~empty;
  assign rsp_err_o     = mst_rsp_i.rvalid & empty;
  assign busy_o        = count != '0;
  for (genvar i = 0; i < NumReq; i++) begin : g_rsp
    assign slv_rsp_o[i].gnt     = hs && win == IdW'(i);
    assign slv_rsp_o[i].rvalid  = pop && head == IdW'(i);
    assign slv_rsp_o[i].r.rdata = slv_rsp_o[i].rvalid ? mst_rsp_i.r.rdata : '0;
    assign slv_rsp_o[i].r.err   = slv_rsp_o[i].rvalid & mst_rsp_i.r.err;
  end
  // An ungranted address phase pins the winner until handshake or OBI-violating withdrawal.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (hs) begin
      rr_q   <= (win == IdW'(NumReq - 1)) ? '0 : win + 1'b1;
      lock_q <= 1'b0;
    end else if (mst_req_o.req) begin
      lock_q    <= 1'b1;
      lock_id_q <= win;
    end else if (lock_q && !slv_req_i[lock_id_q].req) begin
      lock_q <= 1'b0;
    end
  end
  obi_instr_arb_id_fifo #(
    .Depth(MaxOutstanding),
    .W    (IdW)
  ) u_id_fifo (
    .clk  (clk_i),
    .rst  (rst_i),
    .push (hs),
    .pop  (pop),
    .data (win),
    .head (head),
    .full (full),
    .empty(empty),
    .count(count)
  );
`ifdef OBI_INSTR_ARB_PERF_EN
  logic any_req;
  always_comb begin
    any_req = 1'b0;
    for (int i = 0; i < NumReq; i++) any_req = any_req | slv_req_i[i].req;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_grant_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else if (perf_clr_i) begin
      perf_grant_cnt_o <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++)
        if (hs && win == IdW'(i) && !(&perf_grant_cnt_o[i])) perf_grant_cnt_o[i] <= perf_grant_cnt_o[i] + 1;
      if (any_req && !hs && !(&perf_stall_cnt_o)) perf_stall_cnt_o <= perf_stall_cnt_o + 1;
    end
  end
`endif
endmodule
